alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: one-cycle arithmetic/logic/shift ops plus an optional iterative shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the MUL state for opcode 8; otherwise opcode 8 is treated as unsupported.
module alu_seq #(
   parameter int NBits = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NBits-1:0] A,
   input  logic [NBits-1:0] B,
   input  logic             carry_in,
   input  logic [3:0]       selection,
   output logic             busy,
   output logic             done,
   output logic [NBits-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             carry_out
);

   localparam logic [NBits-1:0] WIDTH_VAL = NBits'(NBits);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
   localparam int CW = (NBits > 1) ? $clog2(NBits) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(NBits - 1);

   logic [2*NBits-1:0] mcand_reg;
   logic [NBits-1:0]   mplier_reg;
   logic [2*NBits-1:0] acc_reg;
   logic [2*NBits-1:0] acc_next;
   logic [CW-1:0]      cnt_reg;
`else
   typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

   state_t           state_reg;
   logic [NBits-1:0] a_reg;
   logic [NBits-1:0] b_reg;
   logic             cin_reg;
   logic [3:0]       sel_reg;

   logic [NBits:0]   sum_ext;
   logic [NBits:0]   diff_ext;
   logic             big_shift;
   logic [NBits-1:0] res_next;
   logic             cout_next;
   logic             ovf_next;

   // Single-cycle datapath, evaluated on the captured operands during EXEC.
   always_comb begin
      sum_ext   = {1'b0, a_reg} + {1'b0, b_reg} + {{NBits{1'b0}}, cin_reg};
      diff_ext  = {1'b0, a_reg} - {1'b0, b_reg};
      big_shift = (b_reg >= WIDTH_VAL);
      res_next  = '0;
      cout_next = 1'b0;
      ovf_next  = 1'b0;
      case (sel_reg)
         4'd0: begin
            res_next  = sum_ext[NBits-1:0];
            cout_next = sum_ext[NBits];
            ovf_next  = (a_reg[NBits-1] == b_reg[NBits-1]) &&
                        (sum_ext[NBits-1] != a_reg[NBits-1]);
         end
         4'd1: begin
            res_next  = diff_ext[NBits-1:0];
            cout_next = ~diff_ext[NBits];
            ovf_next  = (a_reg[NBits-1] != b_reg[NBits-1]) &&
                        (diff_ext[NBits-1] != a_reg[NBits-1]);
         end
         4'd2: res_next = a_reg & b_reg;
         4'd3: res_next = a_reg | b_reg;
         4'd4: res_next = a_reg ^ b_reg;
         4'd5: res_next = big_shift ? '0 : (a_reg << b_reg);
         4'd6: res_next = big_shift ? '0 : (a_reg >> b_reg);
         4'd7: res_next = big_shift ? {NBits{a_reg[NBits-1]}}
                                    : NBits'($signed(a_reg) >>> b_reg);
         default: res_next = '0;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   always_comb begin
      acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         negative   <= 1'b0;
         overflow   <= 1'b0;
         carry_out  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         cin_reg    <= 1'b0;
         sel_reg    <= '0;
`ifdef ALU_SEQ_MUL_EN
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Also reached in the done cycle, which gives back-to-back acceptance.
               if (start) begin
                  a_reg     <= A;
                  b_reg     <= B;
                  cin_reg   <= carry_in;
                  sel_reg   <= selection;
                  busy      <= 1'b1;
                  state_reg <= EXEC;
`ifdef ALU_SEQ_MUL_EN
                  mcand_reg  <= {{NBits{1'b0}}, A};
                  mplier_reg <= B;
                  acc_reg    <= '0;
                  cnt_reg    <= '0;
                  if (selection == 4'd8) state_reg <= MUL;
`endif
               end
            end
            EXEC: begin
               result    <= res_next;
               zero      <= (res_next == '0);
               negative  <= res_next[NBits-1];
               overflow  <= ovf_next;
               carry_out <= cout_next;
               busy      <= 1'b0;
               done      <= 1'b1;
               state_reg <= IDLE;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_ITER) begin
                  result    <= acc_next[NBits-1:0];
                  zero      <= (acc_next[NBits-1:0] == '0);
                  negative  <= acc_next[NBits-1];
                  overflow  <= |acc_next[2*NBits-1:NBits];
                  carry_out <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= IDLE;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
